// File: rtl/pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit
//   Stall/flush sequencer for the five-stage RV32i pipeline. Combines load-use
//   hazards, execute-stage branch mispredictions and data-memory wait states
//   into the stall/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. A small FSM adds a post-reset flush window, a memory-wait
//   timeout and a sticky error halt.
//
//   Optional feature macro: PIPE_PERF_CNT_EN
//     defined   -> saturating Stall_Count / Flush_Count performance counters
//     undefined -> both count ports tied to zero, no counter flops
// -----------------------------------------------------------------------------
module pipeline_control_unit #(
   parameter int unsigned RESET_FLUSH_CYCLES = 2,
   parameter int unsigned MEM_TIMEOUT        = 16,
   parameter int unsigned CNT_WIDTH          = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [4:0]           Rs1_D,
   input  logic [4:0]           Rs2_D,
   input  logic [4:0]           Rd_E,
   input  logic                 Mem_Read_E,
   input  logic                 Valid_E,
   input  logic                 Mispredict_E,
   input  logic                 Mem_Req_M,
   input  logic                 Mem_Ready_M,
   output logic                 Stall_F,
   output logic                 Stall_En,
   output logic                 Stall_E,
   output logic                 Stall_M,
   output logic                 Flush_D,
   output logic                 Flush_E,
   output logic                 Flush_W,
   output logic                 Mem_Error,
   output logic [CNT_WIDTH-1:0] Stall_Count,
   output logic [CNT_WIDTH-1:0] Flush_Count
);

   // wait_cnt only has to reach MEM_TIMEOUT, so it can never wrap.
   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned HOLD_W = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_FLUSH_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RESET_HOLD,
      RUN,
      MEM_WAIT,
      ERROR
   } state_e;

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

   logic                mem_block;
   logic                mispredict;
   logic                load_use;

   // A stalled memory access blocks everything; x0 never carries a dependence
   // and a bubble in execute can neither mispredict nor cause a load-use stall.
   assign mem_block  = Mem_Req_M & ~Mem_Ready_M;
   assign mispredict = Mispredict_E & Valid_E;
   assign load_use   = Mem_Read_E & Valid_E & (Rd_E != 5'd0) &
                       ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));

   // State and cycle counters; RST returns to the flush window immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= RESET_HOLD;
         wait_cnt_q <= '0;
         hold_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Next-state and same-cycle stall/flush controls, in priority order.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      hold_cnt_d = hold_cnt_q;
      Stall_F    = 1'b0;
      Stall_En   = 1'b0;
      Stall_E    = 1'b0;
      Stall_M    = 1'b0;
      Flush_D    = 1'b0;
      Flush_E    = 1'b0;
      Flush_W    = 1'b0;
      Mem_Error  = 1'b0;

      case (state_q)
         RESET_HOLD: begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
            Flush_W = 1'b1;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end

         RUN: begin
            if (mem_block) begin
               Stall_F    = 1'b1;
               Stall_En   = 1'b1;
               Stall_E    = 1'b1;
               Stall_M    = 1'b1;
               Flush_W    = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else if (mispredict) begin
               Flush_D = 1'b1;
               Flush_E = 1'b1;
            end else if (load_use) begin
               // One bubble into EX; the hazard is re-evaluated next cycle.
               Stall_F  = 1'b1;
               Stall_En = 1'b1;
               Flush_E  = 1'b1;
            end
         end

         MEM_WAIT: begin
            // EX is frozen here, so branch and load-use hazards wait for RUN.
            if (Mem_Ready_M) begin
               state_d = RUN;
            end else begin
               Stall_F  = 1'b1;
               Stall_En = 1'b1;
               Stall_E  = 1'b1;
               Stall_M  = 1'b1;
               Flush_W  = 1'b1;
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d = ERROR;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
         end

         ERROR: begin
            Stall_F   = 1'b1;
            Stall_En  = 1'b1;
            Stall_E   = 1'b1;
            Stall_M   = 1'b1;
            Flush_W   = 1'b1;
            Mem_Error = 1'b1;
         end

         default: begin
            state_d = RESET_HOLD;
         end
      endcase
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating counters: stalled-PC cycles and mispredict flushes seen in RUN.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (Stall_F && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
      if (Flush_D && (state_q == RUN) && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Counter registers, cleared by RST.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign Stall_Count = stall_cnt_q;
   assign Flush_Count = flush_cnt_q;
`else
   assign Stall_Count = '0;
   assign Flush_Count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_control_unit
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural model of the stall/flush rules. Compile with PIPE_PERF_CNT_EN
//   to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_pipeline_control_unit;

   localparam int RFC = 2;
   localparam int TMO = 16;
   localparam int CW  = 32;

   logic          CLK = 1'b0;
   logic          RST;
   logic [4:0]    Rs1_D, Rs2_D, Rd_E;
   logic          Mem_Read_E, Valid_E, Mispredict_E, Mem_Req_M, Mem_Ready_M;
   logic          Stall_F, Stall_En, Stall_E, Stall_M;
   logic          Flush_D, Flush_E, Flush_W, Mem_Error;
   logic [CW-1:0] Stall_Count, Flush_Count;

   always #5 CLK = ~CLK;

   pipeline_control_unit #(
      .RESET_FLUSH_CYCLES (RFC),
      .MEM_TIMEOUT        (TMO),
      .CNT_WIDTH          (CW)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .Rs1_D        (Rs1_D),
      .Rs2_D        (Rs2_D),
      .Rd_E         (Rd_E),
      .Mem_Read_E   (Mem_Read_E),
      .Valid_E      (Valid_E),
      .Mispredict_E (Mispredict_E),
      .Mem_Req_M    (Mem_Req_M),
      .Mem_Ready_M  (Mem_Ready_M),
      .Stall_F      (Stall_F),
      .Stall_En     (Stall_En),
      .Stall_E      (Stall_E),
      .Stall_M      (Stall_M),
      .Flush_D      (Flush_D),
      .Flush_E      (Flush_E),
      .Flush_W      (Flush_W),
      .Mem_Error    (Mem_Error),
      .Stall_Count  (Stall_Count),
      .Flush_Count  (Flush_Count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Small IF/ID model: PC advances unless Stall_F, IF/ID captures unless Stall_En.
   logic [31:0] pc_f, pc_d;
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_f <= 32'd0;
         pc_d <= 32'd0;
      end else begin
         if (!Stall_F)  pc_f <= pc_f + 32'd4;
         if (!Stall_En) pc_d <= pc_f;
      end
   end

   // Behavioural model: remaining flush cycles, outstanding wait, halted flag.
   int     hold_left;
   bit     waiting;
   int     waited;
   bit     halted;
   longint m_stall_cnt, m_flush_cnt;

   // Control vector: {Stall_F,Stall_En,Stall_E,Stall_M,Flush_D,Flush_E,Flush_W,Mem_Error}
   localparam logic [7:0] V_IDLE  = 8'b0000_0000;
   localparam logic [7:0] V_FLUSH = 8'b0000_1110;
   localparam logic [7:0] V_MEM   = 8'b1111_0010;
   localparam logic [7:0] V_HALT  = 8'b1111_0011;
   localparam logic [7:0] V_MISP  = 8'b0000_1100;
   localparam logic [7:0] V_LOAD  = 8'b1100_0100;

   function automatic logic [7:0] ctrl_now();
      return {Stall_F, Stall_En, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, Mem_Error};
   endfunction

   function automatic logic [7:0] model_ctrl();
      bit dep;
      dep = Mem_Read_E && Valid_E && (Rd_E != 0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);
      if (halted)                      return V_HALT;
      if (hold_left > 0)               return V_FLUSH;
      if (waiting)                     return Mem_Ready_M ? V_IDLE : V_MEM;
      if (Mem_Req_M && !Mem_Ready_M)   return V_MEM;
      if (Mispredict_E && Valid_E)     return V_MISP;
      if (dep)                         return V_LOAD;
      return V_IDLE;
   endfunction

   task automatic model_reset();
      hold_left   = RFC;
      waiting     = 1'b0;
      waited      = 0;
      halted      = 1'b0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
   endtask

   task automatic check_counters(input string tag);
`ifdef PIPE_PERF_CNT_EN
      check({tag, "_stall_cnt"}, Stall_Count, m_stall_cnt);
      check({tag, "_flush_cnt"}, Flush_Count, m_flush_cnt);
`else
      check({tag, "_stall_cnt"}, Stall_Count, 0);
      check({tag, "_flush_cnt"}, Flush_Count, 0);
`endif
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic ve, input logic mp,
                         input logic rq, input logic rdy);
      Rs1_D = rs1; Rs2_D = rs2; Rd_E = rd;
      Mem_Read_E = mr; Valid_E = ve; Mispredict_E = mp;
      Mem_Req_M = rq; Mem_Ready_M = rdy;
   endtask

   // One clock: compare at the falling edge, advance the model, return at posedge+1.
   task automatic cycle(input string tag, output logic [7:0] seen);
      logic [7:0] exp;
      bit         in_run;
      @(negedge CLK);
      exp  = model_ctrl();
      seen = ctrl_now();
      check({tag, "_ctrl"}, seen, exp);
      check_counters(tag);
      in_run = !halted && hold_left == 0 && !waiting;
      if (exp[7]) m_stall_cnt++;
      if (exp[3] && in_run) m_flush_cnt++;
      if (halted) begin
      end else if (hold_left > 0) begin
         hold_left--;
      end else if (waiting) begin
         if (Mem_Ready_M)        waiting = 1'b0;
         else if (waited == TMO) halted  = 1'b1;
         else                    waited++;
      end else if (Mem_Req_M && !Mem_Ready_M) begin
         waiting = 1'b1;
         waited  = 1;
      end
      @(posedge CLK);
      #1;
   endtask

   // Assert RST mid-cycle, check the asynchronous response, release after n edges.
   task automatic do_reset(input int n);
      RST = 1'b1;
      #1;
      model_reset();
      check("rst_async_ctrl", ctrl_now(), V_FLUSH);
      check_counters("rst_async");
      repeat (n) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  g;
      logic [31:0] pc_hold;

      // ---- Test 1: RST held three cycles, two-cycle flush window ----
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      RST = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("t1_rst_ctrl", ctrl_now(), V_FLUSH);
         check_counters("t1_rst");
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      cycle("t1_hold0", g); check("t1_hold0_const", g, V_FLUSH);
      cycle("t1_hold1", g); check("t1_hold1_const", g, V_FLUSH);
      cycle("t1_run",   g); check("t1_run_const",   g, V_IDLE);

      // ---- Test 2: load-use on Rs2, then the same with Rd_E = x0 ----
      set_in(5'd3, 5'd5, 5'd5, 1, 1, 0, 0, 0);
      cycle("t2_lu", g); check("t2_lu_const", g, V_LOAD);
      set_in(5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
      cycle("t2_x0", g); check("t2_x0_const", g, V_IDLE);
      set_in(5'd5, 5'd5, 5'd5, 1, 0, 0, 0, 0);
      cycle("t2_bubble", g); check("t2_bubble_const", g, V_IDLE);

      // ---- Test 4: four memory wait cycles, then ready; IF/ID must hold ----
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      pc_hold = pc_d;
      for (int i = 0; i < 4; i++) begin
         cycle("t4_wait", g);
         check("t4_wait_const", g, V_MEM);
         check("t4_ifid_hold", pc_d, pc_hold);
      end
      Mem_Ready_M = 1'b1;
      cycle("t4_ready", g); check("t4_ready_const", g, V_IDLE);
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      cycle("t4_rdy_noreq", g); check("t4_rdy_noreq_const", g, V_IDLE);

`ifdef PIPE_PERF_CNT_EN
      check("t6_stall_count", Stall_Count, 5);
      check("t6_flush_count", Flush_Count, 0);
`endif

      // ---- Test 3: mispredict wins over a simultaneous load-use ----
      set_in(5'd7, 5'd1, 5'd7, 1, 1, 1, 0, 0);
      cycle("t3_misp", g); check("t3_misp_const", g, V_MISP);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      cycle("t3_idle", g);

`ifdef PIPE_PERF_CNT_EN
      check("t6_flush_after_misp", Flush_Count, 1);
`endif

      // ---- Test 5: memory timeout, sticky error, cleared by RST ----
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < TMO + 1; i++) begin
         cycle("t5_wait", g);
         if (i == TMO) check("t5_last_wait_no_err", g[0], 1'b0);
      end
      cycle("t5_err", g); check("t5_err_const", g, V_HALT);
      for (int i = 0; i < 6; i++) begin
         set_in(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
         cycle("t5_sticky", g);
         check("t5_sticky_err", g[0], 1'b1);
      end
      do_reset(1);
      check("t5_err_cleared", Mem_Error, 1'b0);

      // ---- Randomized traffic in several reset-separated blocks ----
      for (int blk = 0; blk < 5; blk++) begin
         if (blk != 0) do_reset(1 + $urandom_range(0, 2));
         for (int n = 0; n < 300; n++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3),
                   ($urandom_range(0, 9) < 6));
            if (waiting) Mem_Req_M = 1'b1;
            cycle("rand", g);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
